// File: rtl/zap_sync_pkg.sv
// Shared limits, types and helpers for the zap_sync_filter_array slice.
package zap_sync_pkg;

    localparam int unsigned SYNC_MAX_STAGES = 4;
    localparam int unsigned SYNC_MAX_FILTER = 255;

    // Filter condition of one channel: settled, or a change waiting to commit.
    typedef enum logic {
        FILT_IDLE,
        FILT_PENDING
    } filt_state_e;

    // Counter width needed to hold 0..filter.
    function automatic int unsigned sync_cnt_w(input int unsigned filter);
        return (filter < 1) ? 1 : $clog2(filter + 1);
    endfunction

    function automatic bit sync_stages_ok(input int unsigned stages);
        return (stages >= 2) && (stages <= SYNC_MAX_STAGES);
    endfunction

    function automatic bit sync_filter_ok(input int unsigned filter);
        return (filter >= 1) && (filter <= SYNC_MAX_FILTER);
    endfunction

endpackage

// File: rtl/zap_sync_filter_channel.sv
// One channel: STAGES-rank synchroniser, optional glitch filter, edge pulses.
// Optional feature macro: ZAP_SYNC_GLITCH_FILTER_EN (filter compiled in when defined).
module zap_sync_filter_channel
    import zap_sync_pkg::*;
#(
    parameter int unsigned STAGES    = 2,
    parameter int unsigned FILTER    = 4,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    if (!sync_stages_ok(STAGES)) begin : g_bad_stages
        $error("zap_sync_filter_channel: STAGES=%0d outside 2..%0d", STAGES, SYNC_MAX_STAGES);
    end
    if (!sync_filter_ok(FILTER)) begin : g_bad_filter
        $error("zap_sync_filter_channel: FILTER=%0d outside 1..%0d", FILTER, SYNC_MAX_FILTER);
    end

    (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] chain;
    logic s;
    logic sync_nxt;
    logic rise_nxt;
    logic fall_nxt;

    assign s = chain[STAGES-1];

    // Synchroniser chain: plain shift, no logic between ranks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], i_async};
        end
    end

`ifdef ZAP_SYNC_GLITCH_FILTER_EN
    localparam int unsigned CW = sync_cnt_w(FILTER);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    filt_state_e   state;

    // Filter decision: count while s disagrees with o_sync, commit on the last count.
    always_comb begin
        state    = (s != o_sync) ? FILT_PENDING : FILT_IDLE;
        cnt_nxt  = '0;
        sync_nxt = o_sync;
        rise_nxt = 1'b0;
        fall_nxt = 1'b0;
        if (state == FILT_PENDING) begin
            if (cnt == CNT_LAST) begin
                sync_nxt = s;
                rise_nxt = s;
                fall_nxt = ~s;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Persistence counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    // Without the filter every change at s is registered one cycle later.
    always_comb begin
        sync_nxt = s;
        rise_nxt = s & ~o_sync;
        fall_nxt = ~s & o_sync;
    end
`endif

    // Output level and edge pulses, all updated in the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_sync <= RESET_VAL;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            o_sync <= sync_nxt;
            o_rise <= rise_nxt;
            o_fall <= fall_nxt;
        end
    end

endmodule

// File: rtl/zap_sync_filter_array.sv
// WIDTH independent synchronise/filter/edge-detect channels for async status pins.
// Optional feature macro: ZAP_SYNC_GLITCH_FILTER_EN (see zap_sync_filter_channel).
module zap_sync_filter_array
    import zap_sync_pkg::*;
#(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       STAGES    = 2,
    parameter int unsigned       FILTER    = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    for (genvar k = 0; k < WIDTH; k++) begin : g_ch
        zap_sync_filter_channel #(
            .STAGES    (STAGES),
            .FILTER    (FILTER),
            .RESET_VAL (RESET_VAL[k])
        ) u_ch (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_async (i_async[k]),
            .o_sync  (o_sync[k]),
            .o_rise  (o_rise[k]),
            .o_fall  (o_fall[k])
        );
    end

endmodule

// File: tb/tb_zap_sync_filter_array.sv
// Self-checking bench for zap_sync_filter_array with a window-based reference model.
module tb_zap_sync_filter_array;

    localparam int          W  = 4;
    localparam int          ST = 2;
    localparam int          FL = 4;
    localparam logic [3:0]  RV = 4'b1010;
`ifdef ZAP_SYNC_GLITCH_FILTER_EN
    localparam int LAT      = ST + FL;
    localparam int SHORT_PL = FL - 1;
    localparam int SHORT_NR = 0;
`else
    localparam int LAT      = ST + 1;
    localparam int SHORT_PL = 1;
    localparam int SHORT_NR = 1;
`endif

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic [W-1:0] i_async = RV;
    logic [W-1:0] o_sync, o_rise, o_fall;

    zap_sync_filter_array #(
        .WIDTH     (W),
        .STAGES    (ST),
        .FILTER    (FL),
        .RESET_VAL (RV)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_async (i_async),
        .o_sync  (o_sync),
        .o_rise  (o_rise),
        .o_fall  (o_fall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: input pipeline plus, with the filter, a window of s history.
    logic [W-1:0] m_pipe [ST];
`ifdef ZAP_SYNC_GLITCH_FILTER_EN
    logic [W-1:0] m_hist [$];
`endif
    logic [W-1:0] m_sync, m_rise, m_fall;
    logic [W-1:0] cur_in  = RV;
    logic         cur_rst = 1'b1;
    int           nr [W];
    int           nf [W];

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge of the reference: commit when the last FL values of s all disagree.
    task automatic model_edge();
        logic [W-1:0] s_b;
        bit           all_diff;
        if (cur_rst) begin
            for (int i = 0; i < ST; i++) m_pipe[i] = RV;
`ifdef ZAP_SYNC_GLITCH_FILTER_EN
            m_hist.delete();
`endif
            m_sync = RV;
            m_rise = '0;
            m_fall = '0;
            return;
        end
        s_b = m_pipe[ST-1];
        for (int i = ST - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = cur_in;
        m_rise = '0;
        m_fall = '0;
`ifdef ZAP_SYNC_GLITCH_FILTER_EN
        m_hist.push_back(s_b);
        if (m_hist.size() > FL) void'(m_hist.pop_front());
        if (m_hist.size() == FL) begin
            for (int k = 0; k < W; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < FL; j++)
                    if (m_hist[j][k] == m_sync[k]) all_diff = 1'b0;
                if (all_diff) begin
                    m_rise[k] = s_b[k];
                    m_fall[k] = ~s_b[k];
                    m_sync[k] = s_b[k];
                end
            end
        end
`else
        all_diff = 1'b0;
        m_rise = s_b & ~m_sync;
        m_fall = ~s_b & m_sync;
        m_sync = s_b;
`endif
    endtask

    // Drive on the falling edge, advance the model on the rising edge, compare 1 time unit later.
    task automatic step();
        @(negedge clk);
        i_async = cur_in;
        i_reset = cur_rst;
        @(posedge clk);
        model_edge();
        #1;
        chk("sync", o_sync, m_sync);
        chk("rise", o_rise, m_rise);
        chk("fall", o_fall, m_fall);
        for (int k = 0; k < W; k++) begin
            nr[k] += int'(o_rise[k]);
            nf[k] += int'(o_fall[k]);
        end
    endtask

    // Hold current inputs for n edges; report the first edge showing any pulse.
    task automatic run_hold(input int n, output int first, output logic [W-1:0] r, output logic [W-1:0] f);
        first = -1;
        r = '0;
        f = '0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (first < 0 && (o_rise | o_fall) != '0) begin
                first = i;
                r = o_rise;
                f = o_fall;
            end
        end
    endtask

    initial begin
        int first;
        logic [W-1:0] r, f;

        for (int k = 0; k < W; k++) begin nr[k] = 0; nf[k] = 0; end

        // Reset with inputs at the reset value.
        cur_rst = 1'b1; cur_in = RV;
        repeat (3) step();
        chk("reset_sync", o_sync, RV);
        chk("reset_rise", o_rise, '0);
        chk("reset_fall", o_fall, '0);

        // Release with inputs equal to RESET_VAL: nothing moves.
        cur_rst = 1'b0;
        run_hold(LAT + 4, first, r, f);
        chk_int("rv_release_quiet", first, -1);
        chk("rv_release_sync", o_sync, RV);

        // Basic latency on channel 0.
        cur_in = RV ^ 4'b0001;
        run_hold(LAT + 3, first, r, f);
        chk_int("latency_edge", first, LAT);
        chk("latency_rise", r, 4'b0001);
        chk("latency_fall", f, 4'b0000);
        chk("latency_sync", o_sync, 4'b1011);

        // Short pulse on channel 2.
        for (int k = 0; k < W; k++) begin nr[k] = 0; nf[k] = 0; end
        cur_in[2] = 1'b1;
        repeat (SHORT_PL) step();
        cur_in[2] = 1'b0;
        repeat (LAT + 6) step();
        chk_int("short_pulse_rise", nr[2], SHORT_NR);
        chk_int("short_pulse_fall", nf[2], SHORT_NR);

        // Pulse of exactly FL cycles on channel 2 always passes.
        for (int k = 0; k < W; k++) begin nr[k] = 0; nf[k] = 0; end
        cur_in[2] = 1'b1;
        repeat (FL) step();
        cur_in[2] = 1'b0;
        repeat (LAT + 6) step();
        chk_int("min_pulse_rise", nr[2], 1);
        chk_int("min_pulse_fall", nf[2], 1);
        chk("min_pulse_sync", o_sync, 4'b1011);

        // Reset while channel 1 change is pending, then change is re-seen after release.
        cur_in = 4'b1001;
        repeat (2) step();
        cur_rst = 1'b1;
        step();
        chk("mid_reset_sync", o_sync, RV);
        cur_rst = 1'b0;
        run_hold(LAT + 3, first, r, f);
        chk_int("mid_reset_edge", first, LAT);
        chk("mid_reset_rise", r, 4'b0001);
        chk("mid_reset_fall", f, 4'b0010);

        // Release with inputs all zero: one fall vector equal to RESET_VAL.
        cur_in = 4'b0000; cur_rst = 1'b1;
        repeat (2) step();
        cur_rst = 1'b0;
        run_hold(LAT + 3, first, r, f);
        chk_int("rel_zero_edge", first, LAT);
        chk("rel_zero_rise", r, 4'b0000);
        chk("rel_zero_fall", f, RV);

        // All channels toggle together.
        cur_in = 4'b1111;
        run_hold(LAT + 3, first, r, f);
        chk_int("all_rise_edge", first, LAT);
        chk("all_rise_vec", r, 4'b1111);
        chk("all_rise_fall", f, 4'b0000);
        cur_in = 4'b0000;
        run_hold(LAT + 3, first, r, f);
        chk_int("all_fall_edge", first, LAT);
        chk("all_fall_vec", f, 4'b1111);
        chk("all_fall_rise", r, 4'b0000);

        // Random toggling with occasional resets, checked every cycle by the model.
        for (int it = 0; it < 200; it++) begin
            cur_in  = W'($urandom);
            cur_rst = ($urandom_range(0, 29) == 0);
            repeat ($urandom_range(1, 7)) step();
        end
        cur_rst = 1'b0;
        repeat (LAT + 4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
